// File: rtl/counter_pkg.sv
// Shared definitions for the threshold counter: direction/mode encodings,
// the per-cycle action type and the bound-detection helper.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int unsigned CNT_MAX_W         = 32;
    localparam int unsigned CNT_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_CLEAR = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_STEP  = 2'd3
    } cnt_action_e;

    // True when a step in direction dir from count would cross the range edge;
    // callers zero-extend count and pass their real width.
    function automatic logic bound_hit(
        input logic [CNT_MAX_W-1:0] count,
        input logic                 dir,
        input int unsigned          width = CNT_DEFAULT_WIDTH
    );
        logic [CNT_MAX_W:0] lim_s;
        logic               hit_s;
        lim_s = ({{CNT_MAX_W{1'b0}}, 1'b1} << width) - {{CNT_MAX_W{1'b0}}, 1'b1};
        if (dir == DIR_UP) begin
            hit_s = (count == lim_s[CNT_MAX_W-1:0]);
        end else begin
            hit_s = (count == {CNT_MAX_W{1'b0}});
        end
        return hit_s;
    endfunction

endpackage

// File: rtl/enable_prescaler.sv
// Divides enabled cycles by PRESCALE into single-cycle ticks; restart
// returns the phase to zero without producing a tick.
module enable_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_pass
            logic unused_s;
            assign unused_s = ^{clk, reset, restart};
            assign tick     = enable;
        end else begin : g_div
            localparam int unsigned   PW   = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] phase_q;
            logic [PW-1:0] phase_d;
            logic          last_s;

            assign last_s = (phase_q == LAST);
            assign tick   = enable & ~restart & last_s;

            // Phase advance, freeze on !enable, zero on restart
            always_comb begin
                phase_d = phase_q;
                if (restart) begin
                    phase_d = {PW{1'b0}};
                end else if (enable) begin
                    if (last_s) begin
                        phase_d = {PW{1'b0}};
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end else begin
                    phase_d = phase_q;
                end
            end

            // Phase register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    phase_q <= {PW{1'b0}};
                end else begin
                    phase_q <= phase_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/threshold_counter.sv
// Up/down counter with wrap/saturate modes, threshold compare, terminal-count
// pulse and sticky overflow, stepped by an optional enable prescaler.
module threshold_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] threshold,
    output logic [WIDTH-1:0] count,
    output logic             valid,
    output logic             tc,
    output logic             overflow
);

    logic             tick_s;
    logic             restart_s;
    logic             at_bound_s;
    logic [WIDTH-1:0] step_s;
    cnt_action_e      action_s;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             overflow_q;
    logic             overflow_d;

    assign restart_s = clear | load;

    enable_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Resolve clear > load > step > hold
    always_comb begin
        action_s = ACT_HOLD;
        if (clear) begin
            action_s = ACT_CLEAR;
        end else if (load) begin
            action_s = ACT_LOAD;
        end else if (tick_s) begin
            action_s = ACT_STEP;
        end else begin
            action_s = ACT_HOLD;
        end
    end

    // Candidate modulo step and bound detection for the current direction
    always_comb begin
        at_bound_s = bound_hit(CNT_MAX_W'(count_q), dir, WIDTH);
        if (dir == DIR_UP) begin
            step_s = count_q + WIDTH'(1);
        end else begin
            step_s = count_q - WIDTH'(1);
        end
    end

    // Next-state for count, tc and overflow; tc defaults low so it is a pulse
    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        overflow_d = overflow_q;
        case (action_s)
            ACT_CLEAR: begin
                count_d    = {WIDTH{1'b0}};
                overflow_d = 1'b0;
            end
            ACT_LOAD: begin
                count_d = load_value;
            end
            ACT_STEP: begin
                if (at_bound_s) begin
                    // A blocked saturating step still counts as a bound event
                    tc_d       = 1'b1;
                    overflow_d = 1'b1;
                    if (sat_mode == MODE_SAT) begin
                        count_d = count_q;
                    end else begin
                        count_d = step_s;
                    end
                end else begin
                    count_d = step_s;
                end
            end
            ACT_HOLD: begin
                count_d = count_q;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= {WIDTH{1'b0}};
            tc_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign overflow = overflow_q;
    assign valid    = (count_q > threshold);

endmodule

// File: tb/tb_threshold_counter.sv
// Directed bench for threshold_counter: two instances (PRESCALE 1 and 3) share
// stimulus; expectations are queued by the driver and checked by a monitor.
module tb_threshold_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic       load;
    logic [3:0] load_value;
    logic       dir;
    logic       sat_mode;
    logic [3:0] threshold;

    logic [3:0] count1;
    logic       valid1, tc1, ovf1;
    logic [3:0] count3;
    logic       valid3, tc3, ovf3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        int         sel;   // 1: PRESCALE=1 instance, 3: PRESCALE=3 instance, 0: both
        logic [3:0] cnt;
        logic       tc;
        logic       ovf;
        logic       vld;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    threshold_counter #(.WIDTH(4), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .dir(dir), .sat_mode(sat_mode), .threshold(threshold),
        .count(count1), .valid(valid1), .tc(tc1), .overflow(ovf1)
    );

    threshold_counter #(.WIDTH(4), .PRESCALE(3)) u_p3 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .dir(dir), .sat_mode(sat_mode), .threshold(threshold),
        .count(count3), .valid(valid3), .tc(tc3), .overflow(ovf3)
    );

    task automatic drive(input logic e, input logic c, input logic l, input logic [3:0] lv,
                         input logic d, input logic s, input logic [3:0] th);
        enable = e; clear = c; load = l; load_value = lv;
        dir = d; sat_mode = s; threshold = th;
    endtask

    task automatic expect_now(input string name, input int sel, input logic [3:0] c,
                              input logic t, input logic o, input logic v);
        exp_t e;
        e.name = name; e.sel = sel; e.cnt = c; e.tc = t; e.ovf = o; e.vld = v;
        exp_q.push_back(e);
    endtask

    // One clock: inputs already driven; expectation is the state after the edge
    task automatic cyc(input string name, input int sel, input logic [3:0] c,
                       input logic t, input logic o, input logic v);
        @(posedge clk);
        #1;
        expect_now(name, sel, c, t, o, v);
        @(negedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [3:0] got, input logic [3:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s %s: got %0d, required %0d", name, field, got, want);
        end
    endtask

    task automatic check_dut(input exp_t e, input string tag, input logic [3:0] c,
                             input logic t, input logic o, input logic v);
        cmp({e.name, "/", tag}, "count", c, e.cnt);
        cmp({e.name, "/", tag}, "tc", {3'd0, t}, {3'd0, e.tc});
        cmp({e.name, "/", tag}, "overflow", {3'd0, o}, {3'd0, e.ovf});
        cmp({e.name, "/", tag}, "valid", {3'd0, v}, {3'd0, e.vld});
    endtask

    // Monitor: compare queued expectations against the DUT at each falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sel != 3) check_dut(e, "p1", count1, tc1, ovf1, valid1);
                if (e.sel != 1) check_dut(e, "p3", count3, tc3, ovf3, valid3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev, nxt;
        logic       t, sticky;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0, DIR_UP, MODE_WRAP, 4'd7);
        cyc("reset_state", 0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Up wrap over 16 steps; tc on the step out of 15
        drive(1'b1, 1'b0, 1'b0, 4'd0, DIR_UP, MODE_WRAP, 4'd7);
        prev = 4'd0;
        sticky = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            t = bound_hit(CNT_MAX_W'(prev), DIR_UP, 4);
            nxt = prev + 4'd1;
            sticky = sticky | t;
            cyc("up_wrap", 1, nxt, t, sticky, nxt > 4'd7);
            prev = nxt;
        end
        enable = 1'b0;
        cyc("up_wrap_tc_once", 1, 4'd0, 1'b0, 1'b1, 1'b0);

        enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cyc("count_to_9", 1, 4'(i), 1'b0, 1'b1, (i > 7) ? 1'b1 : 1'b0);
        end

        // Reset asserted between edges must act with no clock edge
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        expect_now("reset_async", 0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        enable = 1'b1;
        repeat (3) cyc("reset_hold", 0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc("resume", 1, 4'd1, 1'b0, 1'b0, 1'b0);
        cyc("resume", 1, 4'd2, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 1'b1, 1'b0, 4'd0, DIR_UP, MODE_WRAP, 4'd7);
        cyc("clear", 1, 4'd0, 1'b0, 1'b0, 1'b0);

        // Down saturate from 2: 1, 0, 0(tc), 0(tc)
        drive(1'b0, 1'b0, 1'b1, 4'd2, DIR_DOWN, MODE_SAT, 4'd0);
        cyc("load2", 1, 4'd2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 4'd2, DIR_DOWN, MODE_SAT, 4'd0);
        cyc("down_sat_1", 1, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("down_sat_2", 1, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc("down_sat_3", 1, 4'd0, 1'b1, 1'b1, 1'b0);
        cyc("down_sat_4", 1, 4'd0, 1'b1, 1'b1, 1'b0);
        enable = 1'b0;
        cyc("down_sat_idle", 1, 4'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, DIR_DOWN, MODE_WRAP, 4'd0);
        cyc("down_wrap", 1, 4'd15, 1'b1, 1'b1, 1'b1);

        // Threshold compare; load keeps overflow
        drive(1'b0, 1'b0, 1'b1, 4'd4, DIR_UP, MODE_WRAP, 4'd5);
        cyc("thr_load4", 1, 4'd4, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd4, DIR_UP, MODE_WRAP, 4'd5);
        cyc("thr_at5", 1, 4'd5, 1'b0, 1'b1, 1'b0);
        cyc("thr_at6", 1, 4'd6, 1'b0, 1'b1, 1'b1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        threshold = 4'd6;
        expect_now("thr_change", 1, 4'd6, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;

        // Priority cases
        drive(1'b1, 1'b1, 1'b1, 4'd10, DIR_UP, MODE_WRAP, 4'd6);
        cyc("prio_clr_ld_en", 1, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 4'd10, DIR_UP, MODE_WRAP, 4'd6);
        cyc("prio_ld_en", 1, 4'd10, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 4'd15, DIR_UP, MODE_SAT, 4'd6);
        cyc("load15", 1, 4'd15, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 4'd15, DIR_UP, MODE_SAT, 4'd6);
        cyc("up_sat", 1, 4'd15, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 4'd3, DIR_UP, MODE_SAT, 4'd6);
        cyc("ld_at_bound", 1, 4'd3, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, DIR_UP, MODE_SAT, 4'd6);
        cyc("clear_ovf", 1, 4'd0, 1'b0, 1'b0, 1'b0);

        // Prescaler instance
        drive(1'b0, 1'b0, 1'b0, 4'd0, DIR_UP, MODE_WRAP, 4'd15);
        reset = 1'b1;
        cyc("p3_reset", 3, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cyc("p3_count", 3, 4'(i / 3), 1'b0, 1'b0, 1'b0);
        end
        cyc("p3_phase1", 3, 4'd3, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        cyc("p3_frozen", 3, 4'd3, 1'b0, 1'b0, 1'b0);
        cyc("p3_frozen", 3, 4'd3, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        cyc("p3_phase2", 3, 4'd3, 1'b0, 1'b0, 1'b0);
        cyc("p3_tick", 3, 4'd4, 1'b0, 1'b0, 1'b0);
        cyc("p3_phase1b", 3, 4'd4, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 4'd7, DIR_UP, MODE_WRAP, 4'd15);
        cyc("p3_load", 3, 4'd7, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd7, DIR_UP, MODE_WRAP, 4'd15);
        cyc("p3_after_load", 3, 4'd7, 1'b0, 1'b0, 1'b0);
        cyc("p3_after_load", 3, 4'd7, 1'b0, 1'b0, 1'b0);
        cyc("p3_after_load", 3, 4'd8, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/threshold_counter.md
# threshold_counter

Parametrised up/down event counter with runtime threshold compare, a selectable wrap or saturate mode, synchronous clear/load and an optional enable prescaler. It is the general counter primitive for control datapaths: it produces the running count, a `valid` flag when the count exceeds a threshold, a terminal-count pulse and a sticky overflow flag.

## Interface
- `WIDTH`, default 4: counter and threshold width in bits, minimum 2.
- `PRESCALE`, default 1: number of enabled cycles per count step, minimum 1; 1 means a step on every enabled cycle.
- `clk` in, 1 bit: single clock; all state updates on the rising edge.
- `reset` in, 1 bit: asynchronous, active-high; clears all state immediately.
- `enable` in, 1 bit: advances the prescaler; a count step occurs only on a prescaler tick.
- `clear` in, 1 bit: synchronous clear of count, prescaler phase and `overflow`.
- `load` in, 1 bit: synchronous load of `load_value`; also zeroes the prescaler phase.
- `load_value` in, WIDTH bits: value taken on `load`.
- `dir` in, 1 bit: 1 counts up, 0 counts down; sampled on each step.
- `sat_mode` in, 1 bit: 1 saturates at the bounds, 0 wraps; sampled on each step.
- `threshold` in, WIDTH bits: unsigned compare value.
- `count` out, WIDTH bits: registered count.
- `valid` out, 1 bit: combinational, `count > threshold` (unsigned).
- `tc` out, 1 bit: registered one-cycle terminal-count pulse.
- `overflow` out, 1 bit: registered sticky flag.

## Operation
- Priority at each edge: `reset` > `clear` > `load` > step > hold.
- **Prescaler** (`phase`, 0..PRESCALE-1):
  - Advances only when `enable`=1 and no clear or load is active.
  - `tick` = `enable` && `phase`==PRESCALE-1; `phase` wraps to 0 on the tick.
  - With PRESCALE=1, `tick` = `enable`.
  - `enable`=0 freezes `phase` and `count`.
- **Step** (on `tick`):
  - Up: `count`+1. At 2^WIDTH-1, go to 0 if wrapping; hold if saturating.
  - Down: `count`-1. At 0, go to 2^WIDTH-1 if wrapping; hold if saturating.
  - Arithmetic is modulo 2^WIDTH.
- **Bound event**: a step taken while `count` is at the bound for the current direction (max when up, 0 when down), in either mode.
  - Each bound event sets `tc`=1 for exactly the next cycle.
  - Each bound event sets `overflow`.
  - In saturate mode, every blocked step is a separate event.
- **`overflow`**:
  - Cleared only by `reset` or `clear`.
  - `load` does not clear it.
  - If `clear` and a `tick` occur in the same cycle, `clear` wins and `overflow`=0.
- **`clear` or `load`**:
  - No step happens in that cycle.
  - `tc`=0 in the following cycle.
  - `load_value` is accepted unconditionally, including values above `threshold`.
- **`valid`**: follows `count` and `threshold` with zero delay; no registering.

## Timing
- Reset values: `count`=0, `phase`=0, `tc`=0, `overflow`=0. `valid` is therefore 0 during reset.
- Outputs change asynchronously on `reset` assertion. Release is synchronised by the system reset tree, not by this block.
- Step latency: `count` updates at the edge where `tick`=1 is sampled.
- `tc`/`overflow` latency: both update at that same edge, so `tc` coincides with the wrapped (or held) `count`.
- Load/clear latency: 1 edge.
- Reset asserted mid-step: the step is lost; the counter restarts from 0 with phase 0.
- `dir` or `sat_mode` changed between ticks: takes effect at the next step, with no glitch on `count`.

## Structure
- Shared package `counter_pkg`, holding:
  - `DIR_UP`=1'b1, `DIR_DOWN`=1'b0;
  - `MODE_WRAP`=1'b0, `MODE_SAT`=1'b1;
  - the function `bound_hit(count, dir)` used by both RTL and the bench model.
- One sub-module, `enable_prescaler`:
  - Parameter: PRESCALE.
  - Ports: `clk`, `reset`, `enable`, `restart`, `tick`.
  - `restart` = `clear` | `load`.
  - For PRESCALE=1 it degenerates to `tick` = `enable` and has no registers.

## Test plan
- Reset mid-count: count at 9, assert `reset` between edges -> `count`=0, `tc`=0, `overflow`=0 immediately; hold 3 cycles, release -> counting resumes from 0.
- Up wrap (WIDTH=4, PRESCALE=1, `sat_mode`=0): 16 enabled cycles from 0 -> `count` 1..15, then 0; `tc`=1 for one cycle with `count`=0; `overflow`=1 persists until `clear`.
- Down saturate: load 2, `dir`=0, `sat_mode`=1, 4 enabled cycles -> `count` 1, 0, 0, 0; `tc` pulses on the 3rd and 4th steps (back-to-back high); `overflow`=1.
- Threshold: `threshold`=5, count up from 4 -> `valid`=0 at 4 and 5, 1 at 6; change `threshold` to 6 while at 6 -> `valid`=0 in the same cycle.
- Priority: `clear`+`load`+`enable` together -> `count`=0, `overflow`=0; `load`(load_value=10)+`enable` -> `count`=10, no increment, `tc`=0.
- Prescaler (PRESCALE=3): 9 enabled cycles -> `count`=3; drop `enable` for 2 cycles mid-phase -> `count` and phase frozen; `load` mid-phase -> next step exactly 3 enabled cycles later.
